// File: rtl/array_ops_pkg.sv
// Shared types and helpers for the array-operation blocks.
//   state_t   : stream state of the diagonal extractor (IDLE, EMIT)
//   diag_len  : length of the main diagonal of a rows x cols matrix
//   idx_width : width of an index over n entries, never less than 1 bit
package array_ops_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic int diag_len(input int rows, input int cols);
        return (rows < cols) ? rows : cols;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/offdiag_nonzero_detect.sv
// Combinational detector: flag is high when any element off the main
// diagonal of in_mat is nonzero. Only instantiated by the diagonal
// extractor when DIAG_EXTRACT_CHECK_EN is defined.
// Ports:
//   in_mat  in   BIT_WIDTH x [ROWS][COLS] matrix
//   flag    out  1  OR over (in_mat[r][c] != 0) for all r != c
module offdiag_nonzero_detect #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8
) (
    input  logic [BIT_WIDTH-1:0] in_mat [ROWS][COLS],
    output logic                 flag
);

    always_comb begin
        flag = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((r != c) && (in_mat[r][c] != '0)) begin
                    flag = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/diagonal_extract_stream.sv
// Captures a ROWS x COLS matrix on a valid/ready handshake and streams its
// main diagonal out one element per beat, index k = 0 .. DIAG_LEN-1.
// Only the diagonal elements are stored.
//
// Optional feature macro: DIAG_EXTRACT_CHECK_EN
//   When defined, adds output not_diag: registered on accept, high when any
//   off-diagonal element of the accepted matrix is nonzero.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input matrix valid
//   in_ready   out  block can accept a matrix
//   in_mat     in   BIT_WIDTH x [ROWS][COLS] input matrix
//   out_valid  out  out_data valid
//   out_ready  in   consumer accepts beat
//   out_data   out  diagonal element in_mat[k][k]
//   out_idx    out  diagonal index k of the current beat
//   out_last   out  high on beat k == DIAG_LEN-1
//   not_diag   out  (DIAG_EXTRACT_CHECK_EN only) off-diagonal nonzero flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no matrix held; in_ready high once out of reset
// EMIT  | presenting diag[k]; advances on out_ready, reloads on last beat
module diagonal_extract_stream
    import array_ops_pkg::*;
#(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int DIAG_LEN  = diag_len(ROWS, COLS),
    parameter int IDX_W     = idx_width(DIAG_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_mat [ROWS][COLS],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [IDX_W-1:0]     out_idx,
`ifdef DIAG_EXTRACT_CHECK_EN
    output logic                 out_last,
    output logic                 not_diag
`else
    output logic                 out_last
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIAG_LEN - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       k_q, k_d;
    logic [BIT_WIDTH-1:0]   diag_q [DIAG_LEN];
    logic [BIT_WIDTH-1:0]   diag_d [DIAG_LEN];
    // Holds in_ready low while reset is asserted and releases it on the
    // first clock edge after rst_n rises.
    logic                   ready_en_q, ready_en_d;
    logic                   beat_last;
    logic                   accept;

`ifdef DIAG_EXTRACT_CHECK_EN
    logic                   not_diag_q, not_diag_d;
    logic                   offdiag_flag;

    offdiag_nonzero_detect #(
        .BIT_WIDTH (BIT_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) u_offdiag (
        .in_mat (in_mat),
        .flag   (offdiag_flag)
    );

    assign not_diag = not_diag_q;
`endif

    assign beat_last = (k_q == LAST_IDX);

    // Outputs are decoded from state so an asynchronous reset clears them
    // immediately, without waiting for a clock edge.
    always_comb begin
        in_ready  = ready_en_q &
                    ((state_q == IDLE) ||
                     ((state_q == EMIT) && beat_last && out_ready));
        out_valid = (state_q == EMIT);
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (state_q == EMIT) begin
            out_data = diag_q[k_q];
            out_idx  = k_q;
            out_last = beat_last;
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        diag_d     = diag_q;
        ready_en_d = 1'b1;
`ifdef DIAG_EXTRACT_CHECK_EN
        not_diag_d = not_diag_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    k_d     = '0;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (!beat_last) begin
                        k_d = k_q + 1'b1;
                    end else if (accept) begin
                        // Next matrix loads on the final beat: no bubble.
                        k_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase

        if (accept) begin
            for (int i = 0; i < DIAG_LEN; i++) begin
                diag_d[i] = in_mat[i][i];
            end
`ifdef DIAG_EXTRACT_CHECK_EN
            not_diag_d = offdiag_flag;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ready_en_q <= 1'b0;
            for (int i = 0; i < DIAG_LEN; i++) begin
                diag_q[i] <= '0;
            end
`ifdef DIAG_EXTRACT_CHECK_EN
            not_diag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ready_en_q <= ready_en_d;
            diag_q     <= diag_d;
`ifdef DIAG_EXTRACT_CHECK_EN
            not_diag_q <= not_diag_d;
`endif
        end
    end

endmodule

// File: tb/tb_diagonal_extract_stream.sv
// Directed bench for diagonal_extract_stream: an 8x8 instance and a 3x5
// instance. Inputs are driven and outputs sampled around the falling edge.
module tb_diagonal_extract_stream;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [3:0] in_mat [8][8];
    logic [3:0] out_data;
    logic [2:0] out_idx;

    logic       ns_in_valid, ns_in_ready, ns_out_valid, ns_out_ready, ns_out_last;
    logic [3:0] ns_mat [3][5];
    logic [3:0] ns_out_data;
    logic [1:0] ns_out_idx;

`ifdef DIAG_EXTRACT_CHECK_EN
    logic       not_diag, ns_not_diag;
`endif

    int checks = 0;
    int errors = 0;

    diagonal_extract_stream #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mat    (in_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
`ifdef DIAG_EXTRACT_CHECK_EN
        .out_last  (out_last),
        .not_diag  (not_diag)
`else
        .out_last  (out_last)
`endif
    );

    diagonal_extract_stream #(.BIT_WIDTH(4), .ROWS(3), .COLS(5)) u_ns (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ns_in_valid),
        .in_ready  (ns_in_ready),
        .in_mat    (ns_mat),
        .out_valid (ns_out_valid),
        .out_ready (ns_out_ready),
        .out_data  (ns_out_data),
        .out_idx   (ns_out_idx),
`ifdef DIAG_EXTRACT_CHECK_EN
        .out_last  (ns_out_last),
        .not_diag  (ns_not_diag)
`else
        .out_last  (ns_out_last)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        checks++; if (ns_in_ready !== 1'b1) begin errors++; $display("FAIL release_ns_in_ready: got %b want 1", ns_in_ready); end
    endtask

    // 8x8 stream with diagonal 1..8 and nonzero off-diagonal filler;
    // in_mat is cleared mid-stream and must not disturb the output.
    task automatic test_stream();
        int n = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_mat[r][c] = (r == c) ? 4'(r + 1) : 4'hA;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_valid: got %b want 0", out_valid); end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (cyc == 1)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) in_mat[r][c] = 4'h0;
            #1;
            if (cyc == 0) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_latency: out_valid got %b want 1", out_valid); end
            end
            if (out_valid) begin
                checks++; if (out_data !== 4'(n + 1)) begin errors++; $display("FAIL stream_data[%0d]: got %h want %h", n, out_data, 4'(n + 1)); end
                checks++; if (out_idx !== 3'(n)) begin errors++; $display("FAIL stream_idx[%0d]: got %0d want %0d", n, out_idx, n); end
                checks++; if (out_last !== (n == 7)) begin errors++; $display("FAIL stream_last[%0d]: got %b want %b", n, out_last, (n == 7)); end
                n++;
                if (out_last) break;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL stream_beats: got %0d want 8", n); end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_idle: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        int         n = 0;
        logic       held = 1'b0;
        logic [3:0] h_data;
        logic [2:0] h_idx;
        logic       h_last;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_mat[r][c] = (r == c) ? 4'(15 - r) : 4'h3;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = (cyc % 2 == 1);
            #1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== h_data || out_idx !== h_idx || out_last !== h_last) begin
                    errors++;
                    $display("FAIL bp_hold: got v=%b d=%h i=%0d l=%b want v=1 d=%h i=%0d l=%b",
                             out_valid, out_data, out_idx, out_last, h_data, h_idx, h_last);
                end
            end
            held   = out_valid && !out_ready;
            h_data = out_data;
            h_idx  = out_idx;
            h_last = out_last;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== 4'(15 - n)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", n, out_data, 4'(15 - n)); end
                checks++; if (out_idx !== 3'(n)) begin errors++; $display("FAIL bp_idx[%0d]: got %0d want %0d", n, out_idx, n); end
                n++;
                if (out_last) break;
            end
        end
        checks++; if (n != 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", n); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_idle: out_valid got %b want 0", out_valid); end
    endtask

    // Matrix A (diag 1..8) then B (diag 8..15) with in_valid held: 16
    // consecutive beats, B accepted on A's last beat.
    task automatic test_back_to_back();
        logic [3:0] exp_d;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_mat[r][c] = (r == c) ? 4'(r + 1) : 4'h0;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n == 0)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        in_mat[r][c] = (r == c) ? 4'(8 + r) : 4'h0;
            if (n == 8) in_valid = 1'b0;
            #1;
            exp_d = (n < 8) ? 4'(n + 1) : 4'(n);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", n, out_valid); end
            checks++; if (out_data !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", n, out_data, exp_d); end
            checks++; if (out_idx !== 3'(n % 8)) begin errors++; $display("FAIL b2b_idx[%0d]: got %0d want %0d", n, out_idx, n % 8); end
            checks++; if (out_last !== (n % 8 == 7)) begin errors++; $display("FAIL b2b_last[%0d]: got %b want %b", n, out_last, (n % 8 == 7)); end
            if (n < 8) begin
                checks++; if (in_ready !== (n == 7)) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", n, in_ready, (n == 7)); end
            end
        end
        @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_idle: out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_nonsquare();
        logic [3:0] exp_d [3];
        int         n = 0;
        exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++)
                ns_mat[r][c] = (r == c) ? exp_d[r] : 4'h5;
        @(negedge clk);
        ns_in_valid  = 1'b1;
        ns_out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            ns_in_valid = 1'b0;
            #1;
            if (ns_out_valid) begin
                if (n < 3) begin
                    checks++; if (ns_out_data !== exp_d[n]) begin errors++; $display("FAIL ns_data[%0d]: got %h want %h", n, ns_out_data, exp_d[n]); end
                end
                checks++; if (ns_out_idx !== 2'(n)) begin errors++; $display("FAIL ns_idx[%0d]: got %0d want %0d", n, ns_out_idx, n); end
                checks++; if (ns_out_last !== (n == 2)) begin errors++; $display("FAIL ns_last[%0d]: got %b want %b", n, ns_out_last, (n == 2)); end
                n++;
                if (ns_out_last) break;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL ns_beats: got %0d want 3", n); end
    endtask

    task automatic test_reset_mid();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                in_mat[r][c] = (r == c) ? 4'(r + 2) : 4'h0;
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_idx !== 3'd2) begin errors++; $display("FAIL mid_idx_before: got %0d want 2", out_idx); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        checks++; if (out_idx !== 3'd0) begin errors++; $display("FAIL mid_rst_idx: got %0d want 0", out_idx); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_release_valid: got %b want 0", out_valid); end
    endtask

`ifdef DIAG_EXTRACT_CHECK_EN
    task automatic test_check_en();
        for (int pass = 0; pass < 2; pass++) begin
            int n = 0;
            logic exp_nd;
            exp_nd = (pass == 0);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    in_mat[r][c] = (r == c) ? 4'(r + 1) : 4'h0;
            if (pass == 0) in_mat[2][5] = 4'h1;
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            for (int cyc = 0; cyc < 20; cyc++) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
                if (out_valid) begin
                    checks++; if (not_diag !== exp_nd) begin errors++; $display("FAIL not_diag[%0d][%0d]: got %b want %b", pass, n, not_diag, exp_nd); end
                    n++;
                    if (out_last) break;
                end
            end
            checks++; if (n != 8) begin errors++; $display("FAIL chk_beats[%0d]: got %0d want 8", pass, n); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        ns_in_valid  = 1'b0;
        ns_out_ready = 1'b0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) in_mat[r][c] = 4'h0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) ns_mat[r][c] = 4'h0;

        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_nonsquare();
        test_reset_mid();
`ifdef DIAG_EXTRACT_CHECK_EN
        test_check_en();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
